// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard scoreboard.
package hazard_pkg;

  // Destination field is stored at this fixed width; narrower register
  // addresses are zero-extended on entry.
  localparam int SB_RD_W     = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               regwrite;
    logic               is_load;
  } sb_entry_t;

  function automatic int sel_width(input int nstages);
    return $clog2(nstages + 1);
  endfunction

endpackage

// File: rtl/sb_src_lookup.sv
// Per-operand scoreboard search: youngest matching writer decides forward or stall.
module sb_src_lookup
  import hazard_pkg::*;
#(
  parameter int NSTAGES    = 3,
  parameter int REG_AW     = 5,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  parameter int SELW       = 2
) (
  input  sb_entry_t         entries [1:NSTAGES],
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  output logic [SELW-1:0]   fwd_sel,
  output logic              stall_req
);

  int   win_k;
  int   ready;
  logic win_load;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    win_k     = 0;
    win_load  = 1'b0;
    for (int k = NSTAGES; k >= 1; k--) begin
      if (entries[k].valid && entries[k].regwrite &&
          entries[k].rd == SB_RD_W'(src) && src != '0 && used) begin
        win_k    = k;
        win_load = entries[k].is_load;
      end
    end
    ready     = win_load ? LOAD_READY : ALU_READY;
    fwd_sel   = SELW'(FWD_REGFILE);
    stall_req = 1'b0;
    if (win_k != 0) begin
      if (win_k >= ready) fwd_sel = SELW'(win_k);
      else                stall_req = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Shift-register hazard scoreboard: forwarding selects, load-use stalls, flush bubbles.
// Optional statistics counters are enabled with `define SCOREBOARD_STATS_EN.
module pipe_hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NSTAGES    = 3,
  parameter  int REG_AW     = 5,
  parameter  int ALU_READY  = 1,
  parameter  int LOAD_READY = 2,
  localparam int SELW       = sel_width(NSTAGES)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [SELW-1:0]   fwd_a_sel,
  output logic [SELW-1:0]   fwd_b_sel,
  output logic [3:0]        pend_count,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_regwrite
`ifdef SCOREBOARD_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_stall_cycles,
  output logic [31:0]       stat_flushes
`endif
);

  sb_entry_t entries [1:NSTAGES];
  logic      req_a;
  logic      req_b;

  sb_src_lookup #(
    .NSTAGES(NSTAGES), .REG_AW(REG_AW), .ALU_READY(ALU_READY),
    .LOAD_READY(LOAD_READY), .SELW(SELW)
  ) u_lookup_a (
    .entries(entries), .src(id_rs), .used(id_rs_used),
    .fwd_sel(fwd_a_sel), .stall_req(req_a)
  );

  sb_src_lookup #(
    .NSTAGES(NSTAGES), .REG_AW(REG_AW), .ALU_READY(ALU_READY),
    .LOAD_READY(LOAD_READY), .SELW(SELW)
  ) u_lookup_b (
    .entries(entries), .src(id_rt), .used(id_rt_used),
    .fwd_sel(fwd_b_sel), .stall_req(req_b)
  );

  // A flushed decode slot never stalls: it is being discarded anyway.
  assign stall = id_valid & ~flush & (req_a | req_b);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int k = 1; k <= NSTAGES; k++) entries[k] <= '0;
    end else begin
      for (int k = 2; k <= NSTAGES; k++) entries[k] <= entries[k-1];
      if (flush || stall)
        entries[1] <= '0;
      else
        entries[1] <= '{valid:    id_valid,
                        rd:       SB_RD_W'(id_rd),
                        regwrite: id_regwrite & id_valid,
                        is_load:  id_is_load};
    end
  end

  always_comb begin
    pend_count = '0;
    for (int k = 1; k <= NSTAGES; k++)
      pend_count = pend_count + 4'(entries[k].valid & entries[k].regwrite);
  end

  assign ex_rd       = entries[1].rd[REG_AW-1:0];
  assign ex_regwrite = entries[1].valid & entries[1].regwrite;

`ifdef SCOREBOARD_STATS_EN
  // Clear beats increment; both counters wrap naturally at 2^32.
  always_ff @(posedge CLK) begin
    if (!RST || stat_clr) begin
      stat_stall_cycles <= '0;
      stat_flushes      <= '0;
    end else begin
      if (stall) stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (flush) stat_flushes      <= stat_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_hazard_scoreboard.md
Name: pipe_hazard_scoreboard

Overview:
- Parametrised successor to the fixed 5-stage interlock logic, for the MIPS pipeline top.
- Tracks every in-flight register-writing instruction from EX through WB in a shift-register scoreboard of configurable depth.
- Produces per-operand forwarding selects, load-use/latency stalls and branch-flush bubble insertion for the decode stage.
- Sits between InstructionDecodeStage and the execute stage.
- Replaces hard-wired Rd1..Rd4 / RegWRITE compare chains.

Parameters:
- NSTAGES, 3, number of tracked stages after decode (1 = EX ... NSTAGES = WB); legal 2..8
- REG_AW, 5, register-address width
- ALU_READY, 1, first stage whose output register holds a forwardable ALU result
- LOAD_READY, 2, first stage whose output register holds forwardable load data; must satisfy ALU_READY <= LOAD_READY <= NSTAGES
- SELW, $clog2(NSTAGES+1), width of forwarding selects (derived, not overridden)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous active-low reset
- id_valid  in  1  decode holds a real instruction
- id_rs  in  REG_AW  source A address
- id_rt  in  REG_AW  source B address
- id_rs_used  in  1  source A is actually read
- id_rt_used  in  1  source B is actually read
- id_rd  in  REG_AW  destination address
- id_regwrite  in  1  instruction writes the register file
- id_is_load  in  1  instruction is a load (mem2Reg)
- flush  in  1  taken branch/jump resolved; kill the instruction in decode
- stall  out  1  hold PC and IF/ID; insert bubble into EX
- fwd_a_sel  out  SELW  0 = register file, k = result of stage k
- fwd_b_sel  out  SELW  same encoding for source B
- pend_count  out  4  number of valid writing entries in the scoreboard
- ex_rd  out  REG_AW  destination held in stage-1 entry
- ex_regwrite  out  1  stage-1 entry valid and writing

Behaviour:
- Entry fields: valid, rd, regwrite, is_load.
- Every clock edge: entry[k] <= entry[k-1] for k = 2..NSTAGES; the entry leaving NSTAGES is dropped.
- entry[1] load rule:
  - RST==0: all entries zeroed; on the next cycle stall=0, fwd_*=0, pend_count=0, ex_rd=0, ex_regwrite=0.
  - flush==1: entry[1] <= bubble, regardless of stall.
  - stall==1: entry[1] <= bubble.
  - otherwise: entry[1] <= {id_valid, id_rd, id_regwrite & id_valid, id_is_load}.
- Match for a source s: matches at stage k when entry[k].valid, entry[k].regwrite, entry[k].rd==s, s!=0 and the operand is used. Register 0 never matches.
- Priority: the youngest match (smallest k) wins; older matches are ignored.
- Ready threshold: R = LOAD_READY if the winning entry is_load, else ALU_READY.
- Operand result:
  - winner k >= R: fwd_sel = k.
  - winner k < R: fwd_sel = 0 and the operand requests a stall.
  - no match: fwd_sel = 0.
- stall = id_valid & ~flush & (reqA | reqB). It is combinational from current entries and ID inputs, and is evaluated the same cycle.
- Latency: a load followed immediately by a consumer stalls (LOAD_READY - 1) cycles with defaults. An ALU producer never stalls.
- While stall=1, fwd selects are don't-care to the consumer but are still driven deterministically by the rules above.
- Simultaneous flush and stall: flush wins, stall=0, bubble inserted.
- Reset mid-operation: all in-flight entries are discarded in the same edge.
- pend_count = popcount(valid & regwrite) over all entries. It saturates only by construction (max 8).

Optional Feature:
- Macro: SCOREBOARD_STATS_EN.
- Defined: adds outputs stat_stall_cycles[31:0] and stat_flushes[31:0].
  - stat_stall_cycles increments on each cycle with stall=1.
  - stat_flushes increments on each cycle with flush=1.
  - Both wrap at 2^32, clear on RST==0, and also clear on input stat_clr (1 bit); stat_clr has priority over increment.
- Undefined: these ports and the counters do not exist; all other behaviour is identical.

Decomposition:
- Package hazard_pkg:
  - sb_entry_t struct {valid, rd, regwrite, is_load}
  - FWD_REGFILE=0 constant
  - function computing SELW
- Sub-module sb_src_lookup, combinational and instantiated twice (A, B):
  - inputs: entry array, source address, used flag
  - outputs: fwd_sel, stall_req

Test Plan:
- Back-to-back ALU RAW: add r3 then sub r4,r3,r5 -> fwd_a_sel=1, stall=0; with a one-instruction gap -> fwd_a_sel=2.
- Load-use (defaults): lw r8 then add r9,r8,r8 -> stall=1 for exactly 1 cycle, then fwd_a_sel=fwd_b_sel=2; ex_regwrite=0 during the bubble.
- Priority: writes to r6 enter at stages 3 and 1 (load at 3, ALU at 1), consumer reads r6 -> fwd_sel=1, stall=0.
- Register zero and unused operand: producer rd=0 with consumer rs=0 -> fwd_a_sel=0, stall=0; rt matches but id_rt_used=0 -> fwd_b_sel=0.
- Flush during load-use stall: lw r2 then consumer r2 with flush=1 in the same cycle -> stall=0, bubble enters stage 1, pend_count drops to 0 after NSTAGES cycles.
- Reset with 3 writers in flight: RST=0 for one edge -> pend_count=0 and stall=0 next cycle; with SCOREBOARD_STATS_EN, counters read 0 and stat_stall_cycles counts exactly 1 after a single load-use.
